// File: rtl/rx_packet_ctrl.sv
// rx_packet_ctrl: header detect, payload write to a dual-bank RAM, checksum commit/rollback
// Ports: clk_50/reset (async, active-high); word/word_valid from the byte receiver;
// ram_wr/ram_addr/ram_data RAM write port; pkt_ok/pkt_err result pulses;
// pkt_type bank of current/last packet; busy while in a packet; good_count committed packets.
module rx_packet_ctrl #(
  parameter int PAYLOAD_LEN = 4,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT     = 1024
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic [7:0]        word,
  input  logic              word_valid,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              pkt_ok,
  output logic              pkt_err,
  output logic              pkt_type,
  output logic              busy,
  output logic [15:0]       good_count
);
  localparam int PW = ADDR_W - 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr0_q, ptr0_d, ptr1_q, ptr1_d, wptr_q, wptr_d;
  logic [7:0] cksum_q, cksum_d, cnt_q, cnt_d, ram_data_q, ram_data_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic type_q, type_d, ram_wr_q, ram_wr_d, ok_q, ok_d, err_q, err_d;
  logic [15:0] good_q, good_d;
  logic hdr_c3, commit, expired;
  assign hdr_c3 = word == 8'hC3;
  // a silent cycle with the counter already at TIMEOUT-1 ends the packet
  assign expired = !word_valid && tmo_q == TW'(TIMEOUT - 1);
  assign commit = state_q == CHECK && word_valid && word == cksum_q;
  always_comb begin
    state_d = state_q;
    wptr_d = wptr_q;
    cksum_d = cksum_q;
    cnt_d = cnt_q;
    type_d = type_q;
    ram_wr_d = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ok_d = 1'b0;
    err_d = 1'b0;
    tmo_d = (state_q == IDLE || word_valid) ? '0 : tmo_q + TW'(1);
    ptr0_d = (commit && !type_q) ? wptr_q : ptr0_q;
    ptr1_d = (commit && type_q) ? wptr_q : ptr1_q;
    good_d = commit ? good_q + 16'd1 : good_q;
    case (state_q)
      IDLE: if (word_valid && (word == 8'hA5 || hdr_c3)) begin
        type_d = hdr_c3;
        wptr_d = hdr_c3 ? ptr1_q : ptr0_q;
        cksum_d = '0;
        cnt_d = '0;
        state_d = PAYLOAD;
      end
      PAYLOAD: if (word_valid) begin
        ram_wr_d = 1'b1;
        ram_addr_d = {type_q, wptr_q};
        ram_data_d = word;
        wptr_d = wptr_q + PW'(1);
        cksum_d = cksum_q + word;
        cnt_d = cnt_q + 8'd1;
        state_d = (cnt_q == 8'(PAYLOAD_LEN - 1)) ? CHECK : PAYLOAD;
      end else if (expired) begin
        err_d = 1'b1;
        state_d = IDLE;
      end
      CHECK: if (word_valid || expired) begin
        ok_d = commit;
        err_d = !commit;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_50 or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      ptr0_q <= '0;
      ptr1_q <= '0;
      wptr_q <= '0;
      cksum_q <= '0;
      cnt_q <= '0;
      tmo_q <= '0;
      type_q <= 1'b0;
      ram_wr_q <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ok_q <= 1'b0;
      err_q <= 1'b0;
      good_q <= '0;
    end else begin
      state_q <= state_d;
      ptr0_q <= ptr0_d;
      ptr1_q <= ptr1_d;
      wptr_q <= wptr_d;
      cksum_q <= cksum_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      type_q <= type_d;
      ram_wr_q <= ram_wr_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ok_q <= ok_d;
      err_q <= err_d;
      good_q <= good_d;
    end
  assign ram_wr = ram_wr_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign pkt_ok = ok_q;
  assign pkt_err = err_q;
  assign pkt_type = type_q;
  assign busy = state_q != IDLE;
  assign good_count = good_q;
endmodule

// File: doc/rx_packet_ctrl.md
Name: rx_packet_ctrl

Overview:
- Sequences the serial byte-assembly datapath: consumes assembled 8-bit words and a one-cycle valid strobe from the byte receiver.
- Detects packet headers (0xA5 or 0xC3), collects a fixed-length payload, verifies a trailing checksum, and writes the payload into a dual-bank receive RAM.
- A packet's payload is committed only when its checksum passes. Bad or timed-out packets are rolled back, so the next packet overwrites them.

Parameters:
- PAYLOAD_LEN, 4, payload bytes per packet (1..255).
- ADDR_W, 8, RAM address width. MSB selects the bank; the low ADDR_W-1 bits are the per-bank pointer.
- TIMEOUT, 1024, max clk_50 cycles allowed between consecutive word_valid pulses inside a packet.

Ports:
- clk_50  in  1  50 MHz clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- word  in  8  assembled byte from the byte receiver.
- word_valid  in  1  one-cycle strobe: word holds a new byte.
- ram_wr  out  1  RAM write strobe, one cycle per payload byte.
- ram_addr  out  ADDR_W  RAM write address, {bank, pointer}.
- ram_data  out  8  RAM write data.
- pkt_ok  out  1  one-cycle pulse: packet passed checksum and is committed.
- pkt_err  out  1  one-cycle pulse: checksum mismatch or timeout.
- pkt_type  out  1  type of the current/last packet: 0 = 0xA5 (bank 0), 1 = 0xC3 (bank 1).
- busy  out  1  high in PAYLOAD and CHECK states.
- good_count  out  16  number of committed packets, wraps at 0xFFFF -> 0.

Behaviour:
- Reset (async, active-high):
  - State = IDLE.
  - All outputs 0: ram_wr, ram_addr, ram_data, pkt_ok, pkt_err, pkt_type, busy, good_count.
  - Both committed bank pointers, the working pointer, byte counter, checksum and timeout counter = 0.
  - Reset mid-packet discards the packet silently: no pkt_err, RAM contents untouched.
- State IDLE:
  - word_valid with word = 0xA5 or 0xC3: latch pkt_type (0xA5 -> 0, 0xC3 -> 1); working pointer = that bank's committed pointer; checksum = 0; byte_cnt = 0; timeout counter = 0; go to PAYLOAD.
  - Any other word is ignored.
- State PAYLOAD, on each word_valid:
  - Next cycle: ram_wr = 1, ram_addr = {pkt_type, working pointer}, ram_data = word. One-cycle registered latency.
  - Then working pointer += 1, wrapping modulo 2^(ADDR_W-1) within the bank; checksum += word, modulo 256; byte_cnt += 1.
  - After the PAYLOAD_LEN-th byte, go to CHECK.
  - Header values arriving here are treated as payload data.
- State CHECK, next word_valid:
  - If word == checksum: the next cycle pulses pkt_ok, the bank's committed pointer = working pointer, and good_count += 1.
  - Otherwise: the next cycle pulses pkt_err and the committed pointer is unchanged (rollback).
  - Either way, return to IDLE.
- Timeout:
  - In PAYLOAD/CHECK the counter increments each cycle without word_valid and clears on word_valid.
  - When it reaches TIMEOUT-1 with no word_valid: the next cycle pulses pkt_err, the committed pointer is unchanged, and the state goes to IDLE.
  - word_valid in the expiry cycle wins: the byte is accepted and no timeout occurs.
- ram_wr, pkt_ok and pkt_err are never high in the same cycle. ram_addr and ram_data hold their last values when ram_wr = 0.
- A byte arriving in the same cycle as a pkt_ok/pkt_err pulse is evaluated in IDLE, so back-to-back packets are accepted.
- Each bank's committed pointer wraps independently. The other bank is never touched.
- busy = 1 exactly while the state is PAYLOAD or CHECK.

Test Plan:
- Good 0xA5 packet: A5, 01, 02, 03, 04, 0A (word_valid spaced 8 cycles apart)
  - ram_wr writes 0x00..0x03 with data 01..04, each one cycle after its word_valid.
  - pkt_ok one cycle after the 0A strobe; pkt_type = 0; good_count = 1.
- Bank select: after the previous test, send C3, 10, 20, 30, 40, A0
  - Writes go to 0x80..0x83; pkt_type = 1; pkt_ok; good_count = 2.
- Checksum fail and rollback: A5, 11, 22, 33, 44, 00
  - pkt_err and no pkt_ok.
  - The next packet A5, 01, 01, 01, 01, 04 writes 0x04..0x07 again, overwriting 11..44.
- Timeout: A5, 05, then idle for 1024 cycles
  - Exactly one pkt_err pulse and busy drops.
  - A byte strobed on the expiry cycle instead is accepted with no pkt_err.
- Noise/wrap:
  - 0x00, 0x5A, 0xFF in IDLE produce no writes.
  - 32 good 0xA5 packets: bank 0 pointer wraps from 0x7F to 0x00, and 0x80 is never written from bank 0.
- Reset mid-packet: assert reset after A5, 01, 02
  - All outputs go to 0 immediately (async).
  - After release, a good packet writes from 0x00 and good_count = 1.
